// File: rtl/jtag_axi_tap_driver.sv
// Host-side JTAG initiator: turns DR/IR scan, TLR and idle commands into TMS/TDI
// sequences for a 1149.1 TAP and returns the TDO bits captured during shifts.
module jtag_axi_tap_driver #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = $clog2(DATA_W+1)
) (
   input  logic              tck,
   input  logic              trstn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_type,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              busy,
   output logic              tms,
   output logic              tdi,
   input  logic              tdo
);

   typedef enum logic [3:0] {
      RST_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RTI_WAIT, RESP
   } state_t;

   localparam logic [1:0]       LP_DR   = 2'd0;
   localparam logic [1:0]       LP_IR   = 2'd1;
   localparam logic [1:0]       LP_TLR  = 2'd2;
   localparam logic [LEN_W-1:0] LP_DW   = LEN_W'(DATA_W);
   localparam logic [LEN_W-1:0] LP_ONE  = LEN_W'(1);
   localparam logic [LEN_W-1:0] LP_RSTN = LEN_W'(5);

   state_t              r_state;
   logic [LEN_W-1:0]    r_cnt;
   logic [1:0]          r_type;
   logic [LEN_W-1:0]    r_len;
   logic [DATA_W-1:0]   r_data;
   logic [DATA_W-1:0]   r_resp_data;
   logic                r_cmd_ready;
   logic                r_resp_valid;
   logic                r_busy;
   logic                r_tms;
   logic                r_tdi;
   logic                w_tms;
   logic                w_tdi;
   logic [LEN_W-1:0]    w_len_sat;

   function automatic logic [LEN_W-1:0] f_sat_len(input logic [LEN_W-1:0] i_len);
      return (i_len > LP_DW) ? LP_DW : i_len;
   endfunction

   assign w_len_sat  = f_sat_len(cmd_len);
   assign cmd_ready  = r_cmd_ready;
   assign resp_valid = r_resp_valid;
   assign resp_data  = r_resp_data;
   assign busy       = r_busy;
   assign tms        = r_tms;
   assign tdi        = r_tdi;

   // TMS/TDI for the step the FSM is currently in; SHIFT count 0 is the Capture->Shift step
   always_comb begin
      w_tms = 1'b0;
      w_tdi = 1'b0;
      case (r_state)
         RST_SEQ:               w_tms = (r_cnt < LP_RSTN);
         SEL_DR, SEL_IR, EXIT1: w_tms = 1'b1;
         SHIFT: begin
            if (r_cnt != '0) begin
               w_tdi = r_data[0];
               w_tms = (r_cnt == r_len);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge tck or negedge trstn) begin
      if (!trstn) begin
         r_state      <= RST_SEQ;
         r_cnt        <= '0;
         r_type       <= LP_DR;
         r_len        <= '0;
         r_data       <= '0;
         r_resp_data  <= '0;
         r_cmd_ready  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_busy       <= 1'b1;
      end else begin
         case (r_state)
            RST_SEQ: begin
               if (r_cnt == LP_RSTN) begin
                  r_cnt <= '0;
                  if (r_type == LP_TLR) begin
                     r_state      <= RESP;
                     r_resp_valid <= 1'b1;
                  end else begin
                     r_state     <= IDLE;
                     r_cmd_ready <= 1'b1;
                     r_busy      <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + LP_ONE;
               end
            end
            IDLE: begin
               if (cmd_valid && r_cmd_ready) begin
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_type      <= cmd_type;
                  r_len       <= w_len_sat;
                  r_data      <= cmd_data;
                  r_resp_data <= '0;
                  r_cnt       <= '0;
                  if (cmd_type == LP_TLR) begin
                     r_state <= RST_SEQ;
                  end else if (w_len_sat == '0) begin
                     r_state      <= RESP;
                     r_resp_valid <= 1'b1;
                  end else if (cmd_type[1]) begin
                     r_state <= RTI_WAIT;
                  end else begin
                     r_state <= SEL_DR;
                  end
               end
            end
            SEL_DR:  r_state <= (r_type == LP_IR) ? SEL_IR : CAPTURE;
            SEL_IR:  r_state <= CAPTURE;
            CAPTURE: begin
               r_state <= SHIFT;
               r_cnt   <= '0;
            end
            SHIFT: begin
               // captured bits enter at the top and are right-aligned on the way out
               if (r_cnt != '0) begin
                  r_data      <= r_data >> 1;
                  r_resp_data <= {tdo, r_resp_data[DATA_W-1:1]};
               end
               if (r_cnt == r_len) begin
                  r_state <= EXIT1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + LP_ONE;
               end
            end
            EXIT1:   r_state <= UPDATE;
            UPDATE: begin
               r_state      <= RESP;
               r_resp_valid <= 1'b1;
               r_resp_data  <= r_resp_data >> (LP_DW - r_len);
            end
            RTI_WAIT: begin
               if (r_cnt == r_len - LP_ONE) begin
                  r_state      <= RESP;
                  r_resp_valid <= 1'b1;
                  r_cnt        <= '0;
               end else begin
                  r_cnt <= r_cnt + LP_ONE;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  r_state      <= IDLE;
                  r_resp_valid <= 1'b0;
                  r_cmd_ready  <= 1'b1;
                  r_busy       <= 1'b0;
               end
            end
            default: r_state <= RST_SEQ;
         endcase
      end
   end

   // TAP pins move only on falling edges so they are settled at every rising edge
   always_ff @(negedge tck or negedge trstn) begin
      if (!trstn) begin
         r_tms <= 1'b1;
         r_tdi <= 1'b0;
      end else begin
         r_tms <= w_tms;
         r_tdi <= w_tdi;
      end
   end

endmodule

// File: tb/tb_jtag_axi_tap_driver.sv
// Bench for jtag_axi_tap_driver: a behavioural 1149.1 TAP target plus a bit-stream
// reference model predicting TMS sequences, latencies and captured data.
module tb_jtag_axi_tap_driver;

   localparam int          DW         = 32;
   localparam int          LW         = $clog2(DW+1);
   localparam logic [3:0]  OP_IDCODE  = 4'h2;
   localparam logic [3:0]  OP_USER    = 4'h8;
   localparam logic [31:0] IDCODE_VAL = 32'h1BEEF001;

   logic          tck = 1'b0;
   logic          trstn = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_type = 2'd0;
   logic [LW-1:0] cmd_len = '0;
   logic [DW-1:0] cmd_data = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [DW-1:0] resp_data;
   logic          busy;
   logic          tms;
   logic          tdi;
   logic          tdo;

   int n_cmp = 0;
   int n_err = 0;
   int bad_edge = 0;
   logic mon_en = 1'b0;

   jtag_axi_tap_driver #(.DATA_W(DW), .LEN_W(LW)) dut (
      .tck(tck), .trstn(trstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
      .cmd_len(cmd_len), .cmd_data(cmd_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .busy(busy), .tms(tms), .tdi(tdi), .tdo(tdo)
   );

   always #5 tck = ~tck;

   initial begin
      #400000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   // TAP pins must never move while tck is high
   always @(tms or tdi) if (mon_en && tck) bad_edge++;

   // ---------------- behavioural TAP target ----------------
   typedef enum logic [3:0] {
      T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
      T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR
   } tap_e;

   tap_e        tap_st = T_RTI;
   logic [3:0]  tap_ir = 4'h0;
   logic [3:0]  tap_irsr = 4'h0;
   logic [31:0] tap_sr = '0;
   logic [31:0] tap_user = '0;
   int          tap_n = 1;

   function automatic tap_e tap_next(input tap_e s, input logic m);
      case (s)
         T_TLR:  return m ? T_TLR  : T_RTI;
         T_RTI:  return m ? T_SDR  : T_RTI;
         T_SDR:  return m ? T_SIR  : T_CDR;
         T_CDR:  return m ? T_E1DR : T_SHDR;
         T_SHDR: return m ? T_E1DR : T_SHDR;
         T_E1DR: return m ? T_UDR  : T_PDR;
         T_PDR:  return m ? T_E2DR : T_PDR;
         T_E2DR: return m ? T_UDR  : T_SHDR;
         T_UDR:  return m ? T_SDR  : T_RTI;
         T_SIR:  return m ? T_TLR  : T_CIR;
         T_CIR:  return m ? T_E1IR : T_SHIR;
         T_SHIR: return m ? T_E1IR : T_SHIR;
         T_E1IR: return m ? T_UIR  : T_PIR;
         T_PIR:  return m ? T_E2IR : T_PIR;
         T_E2IR: return m ? T_UIR  : T_SHIR;
         default: return m ? T_SDR : T_RTI;
      endcase
   endfunction

   always @(posedge tck) begin
      case (tap_st)
         T_TLR: tap_ir = OP_IDCODE;
         T_CDR: begin
            if (tap_ir == OP_IDCODE) begin tap_sr = IDCODE_VAL; tap_n = 32; end
            else if (tap_ir == OP_USER) begin tap_sr = tap_user; tap_n = 32; end
            else begin tap_sr = '0; tap_n = 1; end
         end
         T_SHDR: tap_sr = (tap_sr >> 1) | (32'(tdi) << (tap_n - 1));
         T_UDR:  if (tap_ir == OP_USER) tap_user = tap_sr;
         T_CIR:  tap_irsr = 4'b0001;
         T_SHIR: tap_irsr = {tdi, tap_irsr[3:1]};
         T_UIR:  tap_ir = tap_irsr;
         default: ;
      endcase
      tap_st = tap_next(tap_st, tms);
   end

   always @(negedge tck) begin
      if (tap_st == T_SHDR)      tdo = tap_sr[0];
      else if (tap_st == T_SHIR) tdo = tap_irsr[0];
      else                       tdo = 1'($urandom);
   end

   // ---------------- reference model ----------------
   logic [3:0]  ref_ir = OP_IDCODE;
   logic [31:0] ref_user = '0;

   // A scan shifts out the captured register followed by the TDI bits; the register
   // keeps whatever is left of that stream after len bits have left it.
   task automatic ref_cmd(input logic [1:0] ty, input int ln, input logic [31:0] dt,
                          output logic [31:0] er, output logic [63:0] es, output int ec);
      int          L;
      int          n;
      logic [31:0] c;
      logic [95:0] st;
      L  = (ln > DW) ? DW : ln;
      er = '0;
      es = '0;
      ec = 0;
      case (ty)
         2'd0, 2'd1: begin
            if (L > 0) begin
               if (ty == 2'd1)              begin n = 4;  c = 32'h1; end
               else if (ref_ir == OP_IDCODE) begin n = 32; c = IDCODE_VAL; end
               else if (ref_ir == OP_USER)   begin n = 32; c = ref_user; end
               else                          begin n = 1;  c = 32'h0; end
               st = 96'(c) | (96'(dt) << n);
               er = 32'(st & ((96'd1 << L) - 96'd1));
               if (ty == 2'd1)              ref_ir = 4'(st >> L);
               else if (ref_ir == OP_USER)  ref_user = 32'(st >> L);
               ec = L + 5 + ((ty == 2'd1) ? 1 : 0);
               es[0] = 1'b1;
               if (ty == 2'd1) es[1] = 1'b1;
               es[ec-3] = 1'b1;
               es[ec-2] = 1'b1;
            end
         end
         2'd2: begin
            ref_ir = OP_IDCODE;
            ec = 6;
            es = 64'h1F;
         end
         default: ec = L;
      endcase
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset(input int hold);
      @(negedge tck); #1;
      trstn = 1'b0;
      mon_en = 1'b1;
      #1;
      chk("rst_tms", tms, 1);
      chk("rst_tdi", tdi, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_busy", busy, 1);
      for (int i = 0; i < hold; i++) begin
         @(posedge tck); #1;
         chk("rst_hold_rvalid", resp_valid, 0);
         chk("rst_hold_tms", tms, 1);
      end
      @(negedge tck); #1;
      trstn = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(posedge tck);
         chk("rstseq_tms", tms, (i <= 5) ? 1 : 0);
         chk("rstseq_tdi", tdi, 0);
         #1;
         chk("rstseq_ready", cmd_ready, (i == 6) ? 1 : 0);
         chk("rstseq_busy", busy, (i == 6) ? 0 : 1);
         chk("rstseq_rvalid", resp_valid, 0);
      end
      ref_ir = OP_IDCODE;
   endtask

   task automatic run_cmd(input logic [1:0] ty, input int ln, input logic [31:0] dt,
                          input int hold, output logic [31:0] g_resp,
                          output logic [63:0] g_seq, output int g_cyc);
      logic [31:0] er;
      logic [63:0] es;
      int          ec;
      int          w;
      g_resp = '0;
      g_seq  = '0;
      g_cyc  = 0;
      ref_cmd(ty, ln, dt, er, es, ec);
      @(negedge tck);
      cmd_valid = 1'b1;
      cmd_type  = ty;
      cmd_len   = LW'(ln);
      cmd_data  = dt;
      w = 0;
      while (!cmd_ready && w < 100) begin
         @(negedge tck);
         w++;
      end
      chk("accept_wait", w, 0);
      if (w >= 100) begin
         cmd_valid = 1'b0;
         return;
      end
      @(posedge tck); #1;
      cmd_valid = 1'b0;
      cmd_data  = $urandom;
      cmd_len   = LW'($urandom);
      chk("cmd_ready_drop", cmd_ready, 0);
      chk("busy_cmd", busy, 1);
      while (!resp_valid && g_cyc < 100) begin
         @(posedge tck);
         if (g_cyc < 64) g_seq[g_cyc] = tms;
         g_cyc++;
         #1;
      end
      chk("resp_valid", resp_valid, 1);
      if (!resp_valid) return;
      g_resp = resp_data;
      chk("cycles", g_cyc, ec);
      chk("tms_seq", g_seq, es);
      chk("resp_data", resp_data, er);
      for (int k = 0; k < hold; k++) begin
         @(posedge tck); #1;
         chk("hold_rvalid", resp_valid, 1);
         chk("hold_rdata", resp_data, er);
         chk("hold_ready", cmd_ready, 0);
         chk("hold_tms", tms, 0);
      end
      @(negedge tck);
      resp_ready = 1'b1;
      @(posedge tck); #1;
      resp_ready = 1'b0;
      chk("post_rvalid", resp_valid, 0);
      chk("post_ready", cmd_ready, 1);
      chk("post_busy", busy, 0);
      chk("tap_in_rti", tap_st, T_RTI);
      chk("tap_ir", tap_ir, ref_ir);
   endtask

   logic [31:0] gr;
   logic [63:0] gs;
   int          gc;
   int          r;
   int          L;
   logic [3:0]  op;
   logic [31:0] dt;

   initial begin
      do_reset(2);

      // IR scan loading IDCODE opcode
      run_cmd(2'd1, 4, 32'h2, 0, gr, gs, gc);
      chk("ir_dir_resp", gr, 32'h1);
      chk("ir_dir_tms", gs, 64'h183);
      chk("ir_dir_cyc", gc, 10);
      chk("ir_dir_tap", tap_ir, 4'h2);

      // full-length IDCODE read
      run_cmd(2'd0, 32, 32'h0, 0, gr, gs, gc);
      chk("idcode_resp", gr, 32'h1BEEF001);
      chk("idcode_cyc", gc, 37);

      // back-pressure, then an immediate follow-up idle command
      run_cmd(2'd0, 8, $urandom, 10, gr, gs, gc);
      run_cmd(2'd3, 3, 32'h0, 0, gr, gs, gc);
      chk("idle3_cyc", gc, 3);
      chk("idle3_resp", gr, 0);

      // boundaries
      run_cmd(2'd0, 0, 32'hFFFF_FFFF, 1, gr, gs, gc);
      chk("len0_resp", gr, 0);
      chk("len0_tms", gs, 0);
      run_cmd(2'd0, 40, $urandom, 0, gr, gs, gc);
      chk("len40_resp", gr, IDCODE_VAL);
      chk("len40_cyc", gc, 37);
      run_cmd(2'd2, 0, 32'h0, 2, gr, gs, gc);

      // abort during shift step 10 of a 32-bit scan
      @(negedge tck);
      cmd_valid = 1'b1;
      cmd_type  = 2'd0;
      cmd_len   = LW'(32);
      cmd_data  = $urandom;
      @(posedge tck); #1;
      cmd_valid = 1'b0;
      repeat (13) @(posedge tck);
      do_reset(3);
      run_cmd(2'd0, 32, $urandom, 0, gr, gs, gc);
      chk("post_abort_idcode", gr, IDCODE_VAL);

      // randomized command mix
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         dt = $urandom;
         if (r <= 3) begin
            run_cmd(2'd0, $urandom_range(0, 40), dt, $urandom_range(0, 3), gr, gs, gc);
         end else if (r <= 6) begin
            L = $urandom_range(0, 8);
            case ($urandom_range(0, 3))
               0: op = OP_IDCODE;
               1: op = OP_USER;
               2: op = 4'hF;
               default: op = 4'($urandom);
            endcase
            if (L >= 4) dt = (dt & ~(32'hF << (L - 4))) | (32'(op) << (L - 4));
            run_cmd(2'd1, L, dt, $urandom_range(0, 3), gr, gs, gc);
         end else if (r == 7) begin
            run_cmd(2'd2, $urandom_range(0, 40), dt, $urandom_range(0, 3), gr, gs, gc);
         end else begin
            run_cmd(2'd3, $urandom_range(0, 5), dt, $urandom_range(0, 3), gr, gs, gc);
         end
      end

      chk("pin_change_on_high_tck", bad_edge, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
